// File: rtl/tile_scheduler.sv
// Tiled-GEMM sequencer: walks an m_tiles x n_tiles grid (ni inner, mi outer) and
// launches one systolic-array tile at a time, handshaking on tpu_busy.
module tile_scheduler #(
    parameter int IDX_W = 16,
    parameter int TILE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       m_tiles,
    input  logic [7:0]       n_tiles,
    input  logic [15:0]      k_len,
    input  logic             abort,
    input  logic             tpu_busy,
    output logic             tpu_enable,
    output logic [15:0]      tpu_k,
    output logic [IDX_W-1:0] a_base,
    output logic [IDX_W-1:0] b_base,
    output logic [IDX_W-1:0] c_base,
    output logic             busy,
    output logic             done,
    output logic [15:0]      tiles_issued
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_ACK  = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] ADVANCE   = 3'd4;
    localparam logic [2:0] FINISH    = 3'd5;

    localparam logic [IDX_W-1:0] TILE_STEP = IDX_W'(TILE);

    logic [2:0]       state;
    logic [7:0]       m_q;
    logic [7:0]       n_q;
    logic [7:0]       mi;
    logic [7:0]       ni;
    logic             abort_q;
    logic [IDX_W-1:0] k_step;
    logic             last_n;
    logic             last_m;

    // The latched K doubles as the base-address stride; bases wrap modulo 2^IDX_W.
    assign k_step = IDX_W'(tpu_k);
    assign last_n = (ni == n_q - 8'd1);
    assign last_m = (mi == m_q - 8'd1);

    // Strobes decode straight from the state register, so reset clears them too.
    assign tpu_enable = (state == ISSUE);
    assign busy       = (state == ISSUE) || (state == WAIT_ACK) ||
                        (state == WAIT_DONE) || (state == ADVANCE);
    assign done       = (state == FINISH);

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            m_q          <= '0;
            n_q          <= '0;
            mi           <= '0;
            ni           <= '0;
            abort_q      <= 1'b0;
            tpu_k        <= '0;
            a_base       <= '0;
            b_base       <= '0;
            c_base       <= '0;
            tiles_issued <= '0;
        end else begin
            if (state != IDLE && abort) begin
                abort_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        m_q          <= m_tiles;
                        n_q          <= n_tiles;
                        tpu_k        <= k_len;
                        mi           <= '0;
                        ni           <= '0;
                        tiles_issued <= '0;
                        a_base       <= '0;
                        b_base       <= '0;
                        c_base       <= '0;
                        if (m_tiles == 8'd0 || n_tiles == 8'd0 || k_len == 16'd0) begin
                            state <= FINISH;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    tiles_issued <= tiles_issued + 16'd1;
                    state        <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tpu_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tpu_busy) begin
                        state <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (abort_q) begin
                        state <= FINISH;
                    end else if (!last_n) begin
                        ni     <= ni + 8'd1;
                        b_base <= b_base + k_step;
                        c_base <= c_base + TILE_STEP;
                        state  <= ISSUE;
                    end else if (!last_m) begin
                        ni     <= '0;
                        b_base <= '0;
                        mi     <= mi + 8'd1;
                        a_base <= a_base + k_step;
                        c_base <= c_base + TILE_STEP;
                        state  <= ISSUE;
                    end else begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    abort_q <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler: a TPU responder drives tpu_busy, and every launched tile
// is compared against bases computed from the (mi, ni) grid position.
module tb_tile_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  m_tiles;
    logic [7:0]  n_tiles;
    logic [15:0] k_len;
    logic        abort;
    logic        tpu_busy;
    logic        tpu_enable;
    logic [15:0] tpu_k;
    logic [15:0] a_base;
    logic [15:0] b_base;
    logic [15:0] c_base;
    logic        busy;
    logic        done;
    logic [15:0] tiles_issued;

    int n_checks = 0;
    int n_errors = 0;

    tile_scheduler #(.IDX_W(16), .TILE(4)) dut (
        .clk(clk), .reset(reset), .start(start), .m_tiles(m_tiles), .n_tiles(n_tiles),
        .k_len(k_len), .abort(abort), .tpu_busy(tpu_busy), .tpu_enable(tpu_enable),
        .tpu_k(tpu_k), .a_base(a_base), .b_base(b_base), .c_base(c_base), .busy(busy),
        .done(done), .tiles_issued(tiles_issued)
    );

    always #5 clk = ~clk;

    typedef struct {
        int m, n, k, dly, len, ab;
        int exp_tiles, exp_a, exp_b, exp_c;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Number of tiles a run should launch: whole grid, or up to the aborted tile.
    function automatic int model_tiles(input int m, input int n, input int k, input int ab);
        if (m == 0 || n == 0 || k == 0) return 0;
        if (ab >= 0 && ab < m * n) return ab + 1;
        return m * n;
    endfunction

    // One complete run with a TPU that raises busy dly cycles after each enable for
    // len cycles; optionally aborts during tile ab's WAIT_DONE. A stray start with
    // different sizes is also injected mid-run and must be ignored.
    task automatic run_gemm(input int m, input int n, input int k, input int dly,
                            input int len, input int ab, output int got_tiles,
                            output int last_a, output int last_b, output int last_c);
        int exp_tiles, cyc, done_cyc, n_done, busy_from, busy_to, nc, ti, t, mi, ni;
        bit busy_bad, done_busy;
        exp_tiles = model_tiles(m, n, k, ab);
        got_tiles = 0; last_a = 0; last_b = 0; last_c = 0;
        n_done = 0; done_cyc = -1; busy_from = -100; busy_to = -100; ti = -1;
        busy_bad = 1'b0; done_busy = 1'b0;
        @(negedge clk);
        m_tiles = m[7:0]; n_tiles = n[7:0]; k_len = k[15:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 3000 && (done_cyc < 0 || cyc < done_cyc + 3)) begin
            if (tpu_enable) begin
                t  = got_tiles;
                mi = (n > 0) ? t / n : 0;
                ni = (n > 0) ? t % n : 0;
                check($sformatf("a_base tile%0d", t), int'(a_base), (mi * k) % 65536);
                check($sformatf("b_base tile%0d", t), int'(b_base), (ni * k) % 65536);
                check($sformatf("c_base tile%0d", t), int'(c_base), (t * 4) % 65536);
                check($sformatf("tpu_k tile%0d", t), int'(tpu_k), k);
                last_a = int'(a_base); last_b = int'(b_base); last_c = int'(c_base);
                got_tiles++;
                ti = t;
                busy_from = cyc + dly;
                busy_to   = busy_from + len;
            end
            if (done) begin
                n_done++;
                if (n_done == 1) done_cyc = cyc;
                if (busy) done_busy = 1'b1;
            end else if (done_cyc < 0 && !busy) begin
                busy_bad = 1'b1;
            end
            nc = cyc + 1;
            tpu_busy = (nc >= busy_from && nc < busy_to);
            abort    = (ab >= 0 && ti == ab && nc == busy_from + 1);
            if (exp_tiles > 0 && nc == 3) begin
                start = 1'b1; m_tiles = 8'd7; n_tiles = 8'd7; k_len = 16'd3;
            end else begin
                start = 1'b0; m_tiles = m[7:0]; n_tiles = n[7:0]; k_len = k[15:0];
            end
            @(negedge clk);
            cyc++;
        end
        tpu_busy = 1'b0; abort = 1'b0; start = 1'b0;
        check("done_count", n_done, 1);
        check("tiles_launched", got_tiles, exp_tiles);
        check("tiles_issued", int'(tiles_issued), exp_tiles);
        check("busy_until_done", int'(busy_bad), 0);
        check("busy_low_in_finish", int'(done_busy), 0);
        if (exp_tiles == 0) check("zero_done_latency", done_cyc, 1);
    endtask

    initial begin
        vec_t vecs[8];
        int got, la, lb, lc, wait_cnt, n_done_r, n_en_r, busy_r;
        int rm, rn, rk, rab;

        vecs[0] = '{2, 3, 16,    1, 10, -1, 6, 16, 32,    20};
        vecs[1] = '{3, 0, 5,     1, 2,  -1, 0, 0,  0,     0};
        vecs[2] = '{4, 4, 8,     1, 10,  2, 3, 0,  16,    8};
        vecs[3] = '{2, 2, 8,     5, 3,  -1, 4, 8,  8,     12};
        vecs[4] = '{1, 2, 40000, 1, 2,  -1, 2, 0,  40000, 4};
        vecs[5] = '{1, 3, 65535, 2, 1,  -1, 3, 0,  65534, 8};
        vecs[6] = '{0, 2, 4,     1, 1,  -1, 0, 0,  0,     0};
        vecs[7] = '{2, 1, 0,     1, 1,  -1, 0, 0,  0,     0};

        reset = 1'b1; start = 1'b0; m_tiles = '0; n_tiles = '0; k_len = '0;
        abort = 1'b0; tpu_busy = 1'b0;
        repeat (2) @(negedge clk);
        check("reset tpu_enable", int'(tpu_enable), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset tiles_issued", int'(tiles_issued), 0);
        check("reset bases", int'(a_base) + int'(b_base) + int'(c_base) + int'(tpu_k), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_gemm(vecs[i].m, vecs[i].n, vecs[i].k, vecs[i].dly, vecs[i].len, vecs[i].ab,
                     got, la, lb, lc);
            check($sformatf("vec%0d tiles", i), got, vecs[i].exp_tiles);
            check($sformatf("vec%0d last a_base", i), la, vecs[i].exp_a);
            check($sformatf("vec%0d last b_base", i), lb, vecs[i].exp_b);
            check($sformatf("vec%0d last c_base", i), lc, vecs[i].exp_c);
        end

        // Reset while the first tile is in WAIT_DONE: run is abandoned silently.
        @(negedge clk);
        m_tiles = 8'd2; n_tiles = 8'd2; k_len = 16'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cnt = 0;
        while (!tpu_enable && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("reset_seq enable seen", int'(tpu_enable), 1);
        tpu_busy = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_seq busy", int'(busy), 0);
        check("reset_seq tiles_issued", int'(tiles_issued), 0);
        check("reset_seq bases", int'(a_base) + int'(b_base) + int'(c_base) + int'(tpu_k), 0);
        n_done_r = 0; n_en_r = 0; busy_r = 0;
        for (int c = 0; c < 8; c++) begin
            tpu_busy = (c < 3);
            @(negedge clk);
            n_done_r += int'(done);
            n_en_r   += int'(tpu_enable);
            busy_r   += int'(busy);
        end
        check("reset_seq no done", n_done_r, 0);
        check("reset_seq no enable", n_en_r, 0);
        check("reset_seq stays idle", busy_r, 0);
        run_gemm(1, 1, 4, 1, 2, -1, got, la, lb, lc);
        check("after_reset tiles", got, 1);
        check("after_reset bases", la + lb + lc, 0);

        for (int r = 0; r < 16; r++) begin
            rm  = int'($urandom_range(0, 3));
            rn  = int'($urandom_range(0, 3));
            rk  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 65535));
            rab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
            run_gemm(rm, rn, rk, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                     rab, got, la, lb, lc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
